// File: rtl/shift_left_unit_pkg.sv
// Shared constants and types for the datapath left shifter.
// DATA_W is the datapath width; SHIFT_BRANCH turns a word offset into a byte offset.
package shift_left_unit_pkg;

  localparam int DATA_W       = 32;
  localparam int SHIFT_BRANCH = 2;

  typedef logic [$clog2(DATA_W)-1:0] shamt_t;

endpackage

// File: rtl/shift_left_barrel.sv
// Combinational log2-stage logical left barrel shifter.
// Also reports whether any 1-bit fell off the MSB end.
module shift_left_barrel
  import shift_left_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  logic [WIDTH-1:0] stage_s [0:SHW];
  logic [SHW:0]     ovf_s;

  assign stage_s[0] = data;
  assign ovf_s[0]   = 1'b0;

  // Stage k moves by 2**k.  Each stage drops distinct original bits,
  // so OR-ing the dropped bits gives the overflow of the whole shift.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int STEP = 1 << k;
    assign stage_s[k+1] = amt[k] ? {stage_s[k][WIDTH-STEP-1:0], {STEP{1'b0}}}
                                 : stage_s[k];
    assign ovf_s[k+1]   = ovf_s[k] | (amt[k] & (|stage_s[k][WIDTH-1:WIDTH-STEP]));
  end

  assign res = stage_s[SHW];
  assign ovf = ovf_s[SHW];

endmodule

// File: rtl/shift_left_unit.sv
// Registered logical left shifter: fixed SHIFT by default, shamt when use_var=1.
// Result, overflow and valid are all registered; no input reaches an output combinationally.
module shift_left_unit
  import shift_left_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHIFT = SHIFT_BRANCH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             use_var,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] sinal,
  output logic [WIDTH-1:0] sinal_deslocado,
  output logic             overflow,
  output logic             valid
);

  localparam logic [SHW-1:0] SHIFT_AMT = SHW'(SHIFT);

  logic [SHW-1:0]   amt_s;
  logic [WIDTH-1:0] res_s;
  logic             ovf_s;
  logic [WIDTH-1:0] data_r;
  logic             ovf_r;
  logic             valid_r;

  // Select run-time or fixed shift amount.
  always_comb begin
    amt_s = SHIFT_AMT;
    if (use_var) begin
      amt_s = shamt;
    end else begin
      amt_s = SHIFT_AMT;
    end
  end

  shift_left_barrel #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_barrel (
    .data (sinal),
    .amt  (amt_s),
    .res  (res_s),
    .ovf  (ovf_s)
  );

  // Output registers: load on enable, otherwise hold data and drop valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_r  <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
    end else if (enable) begin
      data_r  <= res_s;
      ovf_r   <= ovf_s;
      valid_r <= 1'b1;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign sinal_deslocado = data_r;
  assign overflow        = ovf_r;
  assign valid           = valid_r;

endmodule

// File: tb/tb_shift_left_unit.sv
// Directed bench for shift_left_unit with an expected-result queue.
module tb_shift_left_unit;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        use_var = 1'b0;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] sinal = 32'd0;
  logic [31:0] sinal_deslocado;
  logic        overflow;
  logic        valid;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  exp_t held = '0;

  shift_left_unit dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .use_var         (use_var),
    .shamt           (shamt),
    .sinal           (sinal),
    .sinal_deslocado (sinal_deslocado),
    .overflow        (overflow),
    .valid           (valid)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic uv, input logic [4:0] sh, input logic [31:0] s);
    logic [63:0] w;
    int a;
    exp_t e;
    a = uv ? int'(sh) : 2;
    w = {32'h0, s} << a;
    e.d = w[31:0];
    e.o = |w[63:32];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e, input logic v);
    check({tag, ".data"}, sinal_deslocado, e.d);
    check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e.o});
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, v});
  endtask

  // One clock: drive at negedge, sample 1 time unit after posedge.
  task automatic step(input string tag, input logic en, input logic uv,
                      input logic [4:0] sh, input logic [31:0] s);
    @(negedge clock);
    enable = en;
    use_var = uv;
    shamt = sh;
    sinal = s;
    if (en) sb_q.push_back(model(uv, sh, s));
    @(posedge clock);
    #1;
    if (sb_q.size() > 0) begin
      held = sb_q.pop_front();
      check_outputs(tag, held, 1'b1);
    end else begin
      check_outputs(tag, held, 1'b0);
    end
  endtask

  initial begin
    #3;
    check_outputs("reset_initial", '0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset_held", '0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    step("fixed_0x4", 1'b1, 1'b0, 5'd0, 32'h0000_0004);
    step("fixed_0x8", 1'b1, 1'b0, 5'd0, 32'h0000_0008);
    step("hold_x", 1'b0, 1'bx, 5'bx, 32'hxxxx_xxxx);
    step("fixed_ovf", 1'b1, 1'b0, 5'd0, 32'hC000_0001);
    step("var_31", 1'b1, 1'b1, 5'd31, 32'h0000_0001);
    step("var_0", 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step("var_31_ovf", 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF);
    step("var_4", 1'b1, 1'b1, 5'd4, 32'h1234_5678);
    step("var_16", 1'b1, 1'b1, 5'd16, 32'h0001_8000);
    step("b2b_1", 1'b1, 1'b0, 5'd7, 32'h0000_0001);
    step("b2b_2", 1'b1, 1'b0, 5'd7, 32'h0000_0002);
    step("b2b_3", 1'b1, 1'b0, 5'd7, 32'h0000_0003);
    step("hold_c", 1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF);
    step("hold_c2", 1'b0, 1'b0, 5'd0, 32'h8000_0000);

    for (int i = 0; i < 8; i++) begin
      step("rand", 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end

    // Mid-stream reset between edges clears outputs before the next edge.
    step("pre_rst", 1'b1, 1'b0, 5'd0, 32'h0000_0008);
    @(negedge clock);
    enable = 1'b1;
    sinal = 32'hFFFF_FFFF;
    #2;
    reset = 1'b0;
    #1;
    held = '0;
    check_outputs("async_clear", held, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check_outputs("rst_hold_en", held, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step("post_rst", 1'b1, 1'b1, 5'd1, 32'h8000_0003);
    step("post_rst_hold", 1'b0, 1'b0, 5'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
